// File: rtl/uart_pkg.sv
// Shared UART definitions: baud constant, default oversampling and FSM state codes.
package uart_pkg;

  localparam int unsigned BAUD               = 9600;
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  // IDLE/START/DATA/STOP match the transmitter's codes; GAP reuses its WAIT code (3'b100).
  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StStart = 3'b001,
    StData  = 3'b010,
    StStop  = 3'b011,
    StGap   = 3'b100
  } uart_state_e;

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the line through the chain; reset to idle-high so no false start appears.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_word.sv
// Two-frame 8N1 receiver: rebuilds a 16-bit word (low byte first) from an oversampled line.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE       = OVERSAMPLE_DEFAULT, // even, >= 4
  parameter int unsigned GAP_TIMEOUT_BITS = 4,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic        clk_153k6hz,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] data,
  output logic        valid,
  output logic        fim1,
  output logic        frame_err,
  output logic        timeout_err,
  output logic [2:0]  state
);

  localparam int unsigned TickW    = $clog2(OVERSAMPLE);
  localparam int unsigned GapLimit = OVERSAMPLE * GAP_TIMEOUT_BITS;
  localparam int unsigned GapW     = $clog2(GapLimit);

  localparam logic [TickW-1:0] TickMid = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickEnd = TickW'(OVERSAMPLE - 1);
  localparam logic [GapW-1:0]  GapEnd  = GapW'(GapLimit - 1);

  logic              rxs;
  uart_state_e       state_q;
  logic [TickW-1:0]  tick_q;
  logic [2:0]        bitn_q;
  logic              byte_sel_q;
  logic [7:0]        shift_q;
  logic [7:0]        byte0_q;
  logic [GapW-1:0]   gap_q;
  logic [15:0]       data_q;
  logic              valid_q;
  logic              fim1_q;
  logic              frame_err_q;
  logic              timeout_err_q;

  rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk_i (clk_153k6hz),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rxs)
  );

  // Receive FSM with registered one-cycle status pulses.
  always_ff @(posedge clk_153k6hz or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tick_q        <= '0;
      bitn_q        <= '0;
      byte_sel_q    <= 1'b0;
      shift_q       <= '0;
      byte0_q       <= '0;
      gap_q         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      fim1_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      valid_q       <= 1'b0;
      fim1_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          byte_sel_q <= 1'b0;
          if (!rxs) begin
            tick_q  <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick_q == TickMid) begin
            tick_q <= '0;
            if (!rxs) begin
              bitn_q  <= '0;
              state_q <= StData;
            end else begin
              // Glitch: fall back to wherever we were waiting for a start edge.
              state_q <= byte_sel_q ? StGap : StIdle;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        StData: begin
          if (tick_q == TickEnd) begin
            tick_q          <= '0;
            shift_q[bitn_q] <= rxs;
            if (bitn_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bitn_q <= bitn_q + 1'b1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        StStop: begin
          // Decide at the stop-bit midpoint so a back-to-back start edge is not missed.
          if (tick_q == TickEnd) begin
            tick_q <= '0;
            if (!rxs) begin
              frame_err_q <= 1'b1;
              byte_sel_q  <= 1'b0;
              state_q     <= StIdle;
            end else if (!byte_sel_q) begin
              byte0_q    <= shift_q;
              fim1_q     <= 1'b1;
              byte_sel_q <= 1'b1;
              gap_q      <= '0;
              state_q    <= StGap;
            end else begin
              data_q     <= {shift_q, byte0_q};
              valid_q    <= 1'b1;
              byte_sel_q <= 1'b0;
              state_q    <= StIdle;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        StGap: begin
          // Timeout takes priority over a start edge seen in the same cycle.
          if (gap_q == GapEnd) begin
            timeout_err_q <= 1'b1;
            byte_sel_q    <= 1'b0;
            state_q       <= StIdle;
          end else if (!rxs) begin
            tick_q  <= '0;
            state_q <= StStart;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign fim1        = fim1_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign state       = state_q;

endmodule
